// File: rtl/ex_stage_pkg.sv
// Shared constants, decode-bus layout and divider state encoding for the execute stage.
// Widths and funct codes here mirror the pipeline-wide definitions used by decode and memory.
package ex_stage_pkg;

  localparam int ID_TO_EX_WD  = 159;
  localparam int EX_TO_MEM_WD = 76;
  localparam int EX_TO_ID_WD  = 38;
  localparam int STALL_BUS_WD = 6;
  localparam int DIV_CYCLES   = 32;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [5:0] FN_MFHI = 6'h10;
  localparam logic [5:0] FN_MTHI = 6'h11;
  localparam logic [5:0] FN_MFLO = 6'h12;
  localparam logic [5:0] FN_MTLO = 6'h13;
  localparam logic [5:0] FN_DIV  = 6'h1A;
  localparam logic [5:0] FN_DIVU = 6'h1B;

  // alu_op bit positions, MSB first on the bus
  localparam int OP_ADD  = 11;
  localparam int OP_SUB  = 10;
  localparam int OP_SLT  = 9;
  localparam int OP_SLTU = 8;
  localparam int OP_AND  = 7;
  localparam int OP_NOR  = 6;
  localparam int OP_OR   = 5;
  localparam int OP_XOR  = 4;
  localparam int OP_SLL  = 3;
  localparam int OP_SRL  = 2;
  localparam int OP_SRA  = 1;
  localparam int OP_LUI  = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [11:0] alu_op;
    logic [2:0]  sel_src1;
    logic [3:0]  sel_src2;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        sel_rf_res;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
  } id_ex_t;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_DONE
  } div_state_e;

  function automatic logic [31:0] abs32(input logic [31:0] v, input logic signed_op);
    return (signed_op && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/ex_stage_div_iter.sv
// Restoring 32-iteration divider: busy from the start cycle through the last iteration (33 cycles),
// then one DONE cycle presenting sign-corrected quot/rem; start is ignored unless idle.
module div_iter
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  localparam int CNT_W = $clog2(DIV_CYCLES);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q;
  logic [31:0]      quo_q, rem_q, dvs_q, a_q;
  logic             neg_quo_q, neg_rem_q, dvs_zero_q;
  logic [32:0]      rem_shift, trial;

  // Bit 32 of the trial difference is the borrow: set means the divisor did not fit.
  assign rem_shift = {rem_q, quo_q[31]};
  assign trial     = rem_shift - {1'b0, dvs_q};

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      DIV_IDLE: begin
        if (start) begin
          state_d = DIV_BUSY;
          busy    = 1'b1;
        end
      end
      DIV_BUSY: begin
        busy = 1'b1;
        if (count_q == CNT_W'(DIV_CYCLES - 1)) state_d = DIV_DONE;
      end
      DIV_DONE: begin
        done    = 1'b1;
        state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DIV_IDLE;
      count_q    <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      a_q        <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dvs_zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == DIV_IDLE && start) begin
        count_q    <= '0;
        quo_q      <= abs32(a, signed_op);
        rem_q      <= '0;
        dvs_q      <= abs32(b, signed_op);
        a_q        <= a;
        neg_quo_q  <= signed_op & (a[31] ^ b[31]);
        neg_rem_q  <= signed_op & a[31];
        dvs_zero_q <= (b == 32'd0);
      end else if (state_q == DIV_BUSY) begin
        count_q <= count_q + CNT_W'(1);
        if (!trial[32]) begin
          rem_q <= trial[31:0];
          quo_q <= {quo_q[30:0], 1'b1};
        end else begin
          rem_q <= rem_shift[31:0];
          quo_q <= {quo_q[30:0], 1'b0};
        end
      end
    end
  end

  // Divide-by-zero returns all-ones quotient and the raw dividend as remainder.
  assign quot = dvs_zero_q ? 32'hFFFF_FFFF : (neg_quo_q ? (~quo_q + 32'd1) : quo_q);
  assign rem  = dvs_zero_q ? a_q           : (neg_rem_q ? (~rem_q + 32'd1) : rem_q);

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: one pipeline register, combinational ALU/memory/forwarding outputs behind it.
// DIV/DIVU raise stallreq_for_ex for 33 cycles; downstream stall holds the register, stall[2] alone bubbles it.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_BUS_WD-1:0] stall,
  output logic                    stallreq_for_ex,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [EX_TO_ID_WD-1:0]  ex_to_id_bus,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata
);

  id_ex_t      id_to_ex_bus_r;
  logic        ex_hold, ex_bubble;
  logic [5:0]  opcode, funct;
  logic        is_mfhi, is_mflo, is_mthi, is_mtlo, is_div, is_divu;
  logic [31:0] src1, src2, imm_sext, imm_zext;
  logic [31:0] alu_res, ex_result;
  logic [31:0] hi_r, lo_r;
  logic        div_busy, div_done, div_start, div_committed;
  logic [31:0] div_quot, div_rem;
  logic        fwd_we;
  logic        unused_bits;

  assign ex_hold   = (stall[2] == STOP) && (stall[3] == STOP);
  assign ex_bubble = (stall[2] == STOP) && (stall[3] == NO_STOP);

  always_ff @(posedge clk) begin
    if (rst) begin
      id_to_ex_bus_r <= '0;
    end else if (ex_bubble) begin
      id_to_ex_bus_r <= '0;
    end else if (stall[2] == NO_STOP) begin
      id_to_ex_bus_r <= id_to_ex_bus;
    end
  end

  assign opcode  = id_to_ex_bus_r.inst[31:26];
  assign funct   = id_to_ex_bus_r.inst[5:0];
  assign is_mfhi = (opcode == 6'd0) && (funct == FN_MFHI);
  assign is_mflo = (opcode == 6'd0) && (funct == FN_MFLO);
  assign is_mthi = (opcode == 6'd0) && (funct == FN_MTHI);
  assign is_mtlo = (opcode == 6'd0) && (funct == FN_MTLO);
  assign is_div  = (opcode == 6'd0) && (funct == FN_DIV);
  assign is_divu = (opcode == 6'd0) && (funct == FN_DIVU);

  assign imm_sext = {{16{id_to_ex_bus_r.inst[15]}}, id_to_ex_bus_r.inst[15:0]};
  assign imm_zext = {16'd0, id_to_ex_bus_r.inst[15:0]};

  assign src1 = ({32{id_to_ex_bus_r.sel_src1[0]}} & id_to_ex_bus_r.rdata1)
              | ({32{id_to_ex_bus_r.sel_src1[1]}} & id_to_ex_bus_r.pc)
              | ({32{id_to_ex_bus_r.sel_src1[2]}} & {27'd0, id_to_ex_bus_r.inst[10:6]});
  assign src2 = ({32{id_to_ex_bus_r.sel_src2[0]}} & id_to_ex_bus_r.rdata2)
              | ({32{id_to_ex_bus_r.sel_src2[1]}} & imm_sext)
              | ({32{id_to_ex_bus_r.sel_src2[2]}} & 32'd8)
              | ({32{id_to_ex_bus_r.sel_src2[3]}} & imm_zext);

  always_comb begin
    logic [11:0] op;
    logic [31:0] sra_res;
    op      = id_to_ex_bus_r.alu_op;
    sra_res = $signed(src2) >>> src1[4:0];
    alu_res = ({32{op[OP_ADD]}}  & (src1 + src2))
            | ({32{op[OP_SUB]}}  & (src1 - src2))
            | ({32{op[OP_SLT]}}  & {31'd0, $signed(src1) < $signed(src2)})
            | ({32{op[OP_SLTU]}} & {31'd0, src1 < src2})
            | ({32{op[OP_AND]}}  & (src1 & src2))
            | ({32{op[OP_NOR]}}  & ~(src1 | src2))
            | ({32{op[OP_OR]}}   & (src1 | src2))
            | ({32{op[OP_XOR]}}  & (src1 ^ src2))
            | ({32{op[OP_SLL]}}  & (src2 << src1[4:0]))
            | ({32{op[OP_SRL]}}  & (src2 >> src1[4:0]))
            | ({32{op[OP_SRA]}}  & sra_res)
            | ({32{op[OP_LUI]}}  & {src2[15:0], 16'd0});
  end

  // A divide that finishes while downstream holds EX stays resident; block it from restarting.
  assign div_start = (is_div | is_divu) & ~div_committed;

  always_ff @(posedge clk) begin
    if (rst || !ex_hold) begin
      div_committed <= 1'b0;
    end else if (div_done) begin
      div_committed <= 1'b1;
    end
  end

  div_iter u_div_iter (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .signed_op (is_div),
    .a         (id_to_ex_bus_r.rdata1),
    .b         (id_to_ex_bus_r.rdata2),
    .busy      (div_busy),
    .done      (div_done),
    .quot      (div_quot),
    .rem       (div_rem)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_r <= '0;
      lo_r <= '0;
    end else if (div_done) begin
      hi_r <= div_rem;
      lo_r <= div_quot;
    end else begin
      if (is_mthi) hi_r <= id_to_ex_bus_r.rdata1;
      if (is_mtlo) lo_r <= id_to_ex_bus_r.rdata1;
    end
  end

  assign ex_result = is_mfhi ? hi_r : (is_mflo ? lo_r : alu_res);
  assign fwd_we    = id_to_ex_bus_r.rf_we & ~id_to_ex_bus_r.sel_rf_res;

  assign stallreq_for_ex = div_busy;
  assign ex_to_mem_bus   = {id_to_ex_bus_r.pc, id_to_ex_bus_r.ram_en, id_to_ex_bus_r.ram_wen,
                            id_to_ex_bus_r.sel_rf_res, id_to_ex_bus_r.rf_we,
                            id_to_ex_bus_r.rf_waddr, ex_result};
  assign ex_to_id_bus    = {fwd_we, id_to_ex_bus_r.rf_waddr, ex_result};
  assign data_sram_en    = id_to_ex_bus_r.ram_en;
  assign data_sram_wen   = id_to_ex_bus_r.ram_wen;
  assign data_sram_addr  = alu_res;
  assign data_sram_wdata = id_to_ex_bus_r.rdata2;

  assign unused_bits = ^{stall[5:4], stall[1:0], id_to_ex_bus_r.inst[25:16]};

endmodule
